// File: rtl/riscy_mem_pkg.sv
// rtl/riscy_mem_pkg.sv - shared access-size encodings and byte-enable helper
// Purpose: size codes match RISC-V funct3[1:0] so decode logic can pass them through.
// Ports: none (package).
package riscy_mem_pkg;

  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;

  // Lane enables for an access of the given size at byte offset off.
  // A half at offset 3 truncates to a single lane; such accesses are
  // misaligned and never reach the array.
  function automatic logic [3:0] be_from_size(input logic [1:0] size, input logic [1:0] off);
    logic [3:0] be;
    be = 4'b0000;
    case (size)
      SZ_BYTE: be = 4'b0001 << off;
      SZ_HALF: be = 4'b0011 << off;
      SZ_WORD: be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

endpackage

// File: rtl/mem_lane_align.sv
// rtl/mem_lane_align.sv - store lane alignment, load extract/extend, misalignment detect
// Purpose: purely combinational byte-lane steering for the load/store port.
// Ports:
//   i_st_size/i_st_off/i_st_wdata : store-side access size, byte offset, right-justified data
//   o_st_be/o_st_wdata            : lane enables and lane-replicated store data
//   o_misal                       : access is misaligned or of illegal size
//   i_ld_size/i_ld_off/i_ld_unsigned/i_ld_word : load-side attributes and raw word read
//   o_ld_data                     : extracted and extended load result
module mem_lane_align
  import riscy_mem_pkg::*;
(
  input  logic [1:0]  i_st_size,
  input  logic [1:0]  i_st_off,
  input  logic [31:0] i_st_wdata,
  output logic [3:0]  o_st_be,
  output logic [31:0] o_st_wdata,
  output logic        o_misal,
  input  logic [1:0]  i_ld_size,
  input  logic [1:0]  i_ld_off,
  input  logic        i_ld_unsigned,
  input  logic [31:0] i_ld_word,
  output logic [31:0] o_ld_data
);

  logic [31:0] w_shifted;

  assign o_st_be   = be_from_size(i_st_size, i_st_off);
  assign w_shifted = i_ld_word >> {i_ld_off, 3'b000};

  always_comb begin
    o_misal = 1'b0;
    case (i_st_size)
      SZ_BYTE: o_misal = 1'b0;
      SZ_HALF: o_misal = i_st_off[0];
      SZ_WORD: o_misal = (i_st_off != 2'b00);
      default: o_misal = 1'b1;
    endcase
  end

  // Replicating the data into every lane lets the byte enables alone
  // select the destination, so no shifter is needed on the store path.
  always_comb begin
    o_st_wdata = i_st_wdata;
    case (i_st_size)
      SZ_BYTE: o_st_wdata = {4{i_st_wdata[7:0]}};
      SZ_HALF: o_st_wdata = {2{i_st_wdata[15:0]}};
      default: o_st_wdata = i_st_wdata;
    endcase
  end

  always_comb begin
    o_ld_data = 32'h0;
    case (i_ld_size)
      SZ_BYTE: o_ld_data = {{24{~i_ld_unsigned & w_shifted[7]}}, w_shifted[7:0]};
      SZ_HALF: o_ld_data = {{16{~i_ld_unsigned & w_shifted[15]}}, w_shifted[15:0]};
      SZ_WORD: o_ld_data = w_shifted;
      default: o_ld_data = 32'h0;
    endcase
  end

endmodule

// File: rtl/tcm_word_ram.sv
// rtl/tcm_word_ram.sv - dual-port tightly-coupled word RAM (fetch + load/store)
// Purpose: byte-write-enable dual-port RAM with pipelined valid handshake,
//          optional output register and optional write-to-fetch forwarding.
// Ports:
//   clk, reset                     : clock, asynchronous active-high reset
//   i_req/i_addr -> i_rdata/i_valid: fetch port, word address, read-only
//   d_req/d_we/d_size/d_unsigned/d_addr/d_wdata -> d_rdata/d_valid/d_err:
//                                    load/store port, byte address
module tcm_word_ram
  import riscy_mem_pkg::*;
#(
  parameter int ADDR_W  = 11,
  parameter int OUT_REG = 0,
  parameter int FWD     = 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [31:0]       i_rdata,
  output logic              i_valid,
  input  logic              d_req,
  input  logic              d_we,
  input  logic [1:0]        d_size,
  input  logic              d_unsigned,
  input  logic [ADDR_W+1:0] d_addr,
  input  logic [31:0]       d_wdata,
  output logic [31:0]       d_rdata,
  output logic              d_valid,
  output logic              d_err
);

  localparam int DEPTH = 1 << ADDR_W;

  logic [31:0]       r_mem [DEPTH];
  logic [31:0]       r_a_raw;
  logic [31:0]       r_b_raw;
  logic [3:0]        r_fwd_be;
  logic [31:0]       r_fwd_data;

  logic              r_i_v1;
  logic              r_d_v1;
  logic              r_d_err1;
  logic              r_d_ld1;
  logic [1:0]        r_d_size1;
  logic [1:0]        r_d_off1;
  logic              r_d_uns1;

  logic [ADDR_W-1:0] w_d_word;
  logic [1:0]        w_d_off;
  logic [3:0]        w_st_be;
  logic [31:0]       w_st_wdata;
  logic              w_misal;
  logic [31:0]       w_ld_data;
  logic              w_run;
  logic              w_wr;
  logic [3:0]        w_be;
  logic              w_coll;
  logic [31:0]       w_a_word;
  logic [31:0]       w_a_out1;
  logic [31:0]       w_d_out1;

  assign w_d_word = d_addr[ADDR_W+1:2];
  assign w_d_off  = d_addr[1:0];

  mem_lane_align u_align (
    .i_st_size     (d_size),
    .i_st_off      (w_d_off),
    .i_st_wdata    (d_wdata),
    .o_st_be       (w_st_be),
    .o_st_wdata    (w_st_wdata),
    .o_misal       (w_misal),
    .i_ld_size     (r_d_size1),
    .i_ld_off      (r_d_off1),
    .i_ld_unsigned (r_d_uns1),
    .i_ld_word     (r_b_raw),
    .o_ld_data     (w_ld_data)
  );

  assign w_run  = ~reset;
  assign w_wr   = w_run & d_req & d_we & ~w_misal;
  assign w_be   = w_wr ? w_st_be : 4'b0000;
  assign w_coll = (FWD != 0) && i_req && w_wr && (i_addr == w_d_word);

  // Array and raw read registers carry no reset so the RAM stays inferable;
  // everything they feed downstream is qualified by a reset valid bit.
  always_ff @(posedge clk) begin
    for (int k = 0; k < 4; k++) begin
      if (w_be[k]) r_mem[w_d_word][8*k +: 8] <= w_st_wdata[8*k +: 8];
    end
    if (w_run && i_req) begin
      r_a_raw    <= r_mem[i_addr];
      r_fwd_be   <= w_coll ? w_st_be : 4'b0000;
      r_fwd_data <= w_st_wdata;
    end
    if (w_run && d_req) r_b_raw <= r_mem[w_d_word];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_i_v1    <= 1'b0;
      r_d_v1    <= 1'b0;
      r_d_err1  <= 1'b0;
      r_d_ld1   <= 1'b0;
      r_d_size1 <= SZ_BYTE;
      r_d_off1  <= 2'b00;
      r_d_uns1  <= 1'b0;
    end else begin
      r_i_v1    <= i_req;
      r_d_v1    <= d_req;
      r_d_err1  <= d_req & w_misal;
      r_d_ld1   <= d_req & ~d_we & ~w_misal;
      r_d_size1 <= d_size;
      r_d_off1  <= w_d_off;
      r_d_uns1  <= d_unsigned;
    end
  end

  // Old word read on the accepting edge, patched with the bytes the
  // colliding store wrote on that same edge.
  always_comb begin
    w_a_word = r_a_raw;
    for (int k = 0; k < 4; k++) begin
      if (r_fwd_be[k]) w_a_word[8*k +: 8] = r_fwd_data[8*k +: 8];
    end
  end

  assign w_a_out1 = r_i_v1 ? w_a_word : 32'h0;
  assign w_d_out1 = r_d_ld1 ? w_ld_data : 32'h0;

  generate
    if (OUT_REG != 0) begin : g_out_reg
      logic [31:0] r_i_rdata2;
      logic        r_i_v2;
      logic [31:0] r_d_rdata2;
      logic        r_d_v2;
      logic        r_d_err2;

      always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
          r_i_rdata2 <= 32'h0;
          r_i_v2     <= 1'b0;
          r_d_rdata2 <= 32'h0;
          r_d_v2     <= 1'b0;
          r_d_err2   <= 1'b0;
        end else begin
          r_i_rdata2 <= w_a_out1;
          r_i_v2     <= r_i_v1;
          r_d_rdata2 <= w_d_out1;
          r_d_v2     <= r_d_v1;
          r_d_err2   <= r_d_err1;
        end
      end

      assign i_rdata = r_i_rdata2;
      assign i_valid = r_i_v2;
      assign d_rdata = r_d_rdata2;
      assign d_valid = r_d_v2;
      assign d_err   = r_d_err2;
    end else begin : g_no_out_reg
      assign i_rdata = w_a_out1;
      assign i_valid = r_i_v1;
      assign d_rdata = w_d_out1;
      assign d_valid = r_d_v1;
      assign d_err   = r_d_err1;
    end
  endgenerate

endmodule

// File: tb/tb_tcm_word_ram.sv
// tb/tb_tcm_word_ram.sv - scoreboard bench for tcm_word_ram against a byte-array model
module tb_tcm_word_ram #(
  parameter int OUT_REG = 0,
  parameter int FWD     = 1
);

  localparam int ADDR_W = 11;
  localparam int NB     = 4 << ADDR_W;

  logic              clk;
  logic              reset;
  logic              i_req;
  logic [ADDR_W-1:0] i_addr;
  logic [31:0]       i_rdata;
  logic              i_valid;
  logic              d_req;
  logic              d_we;
  logic [1:0]        d_size;
  logic              d_unsigned;
  logic [ADDR_W+1:0] d_addr;
  logic [31:0]       d_wdata;
  logic [31:0]       d_rdata;
  logic              d_valid;
  logic              d_err;

  tcm_word_ram #(.ADDR_W(ADDR_W), .OUT_REG(OUT_REG), .FWD(FWD)) dut (
    .clk        (clk),
    .reset      (reset),
    .i_req      (i_req),
    .i_addr     (i_addr),
    .i_rdata    (i_rdata),
    .i_valid    (i_valid),
    .d_req      (d_req),
    .d_we       (d_we),
    .d_size     (d_size),
    .d_unsigned (d_unsigned),
    .d_addr     (d_addr),
    .d_wdata    (d_wdata),
    .d_rdata    (d_rdata),
    .d_valid    (d_valid),
    .d_err      (d_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc = cyc + 1;

  typedef struct {
    logic [31:0] data;
    logic        err;
    int          due;
  } exp_t;

  exp_t       qi[$];
  exp_t       qd[$];
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [7:0] mb [NB];

  function automatic logic [31:0] rd_word(input int w);
    return {mb[4*w+3], mb[4*w+2], mb[4*w+1], mb[4*w]};
  endfunction

  // One request slot: drive just after a rising edge, accepted on the next one.
  task automatic issue(input bit ir, input int ia, input bit dr, input bit we,
                       input logic [1:0] sz, input bit un, input int da, input logic [31:0] wd);
    int          n;
    bit          mis;
    logic [31:0] old_f;
    logic [31:0] v;
    exp_t        e;
    @(posedge clk);
    #1;
    i_req      = ir;
    i_addr     = ia[ADDR_W-1:0];
    d_req      = dr;
    d_we       = we;
    d_size     = sz;
    d_unsigned = un;
    d_addr     = da[ADDR_W+1:0];
    d_wdata    = wd;
    n     = (sz == 2'd0) ? 1 : (sz == 2'd1) ? 2 : 4;
    mis   = (sz == 2'd3) || ((da % n) != 0);
    old_f = rd_word(ia);
    if (dr && we && !mis)
      for (int k = 0; k < n; k++) mb[da+k] = wd[8*k +: 8];
    if (ir) begin
      e.data = (FWD != 0) ? rd_word(ia) : old_f;
      e.err  = 1'b0;
      e.due  = cyc + 1 + OUT_REG;
      qi.push_back(e);
    end
    if (dr) begin
      v = 32'h0;
      if (!mis && !we) begin
        for (int k = 0; k < n; k++) v[8*k +: 8] = mb[da+k];
        if (!un && v[8*n-1])
          for (int k = n; k < 4; k++) v[8*k +: 8] = 8'hFF;
      end
      e.data = v;
      e.err  = mis;
      e.due  = cyc + 1 + OUT_REG;
      qd.push_back(e);
    end
  endtask

  task automatic idle();
    issue(1'b0, 0, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      n_cmp++;
      if (i_valid !== 1'b0 || d_valid !== 1'b0 || d_err !== 1'b0 ||
          i_rdata !== 32'h0 || d_rdata !== 32'h0) begin
        n_bad++;
        $display("FAIL reset_outputs: got iv=%b dv=%b de=%b ir=%h dr=%h, want all 0",
                 i_valid, d_valid, d_err, i_rdata, d_rdata);
      end
    end else begin
      if (i_valid === 1'b1) begin
        n_cmp++;
        if (qi.size() == 0) begin
          n_bad++;
          $display("FAIL fetch_unexpected: got i_valid with i_rdata=%h at cycle %0d, want none", i_rdata, cyc);
        end else begin
          e = qi.pop_front();
          if (i_rdata !== e.data || cyc != e.due) begin
            n_bad++;
            $display("FAIL fetch_resp: got %h at cycle %0d, want %h at cycle %0d", i_rdata, cyc, e.data, e.due);
          end
        end
      end else if (qi.size() > 0 && qi[0].due <= cyc) begin
        n_cmp++;
        n_bad++;
        $display("FAIL fetch_missing: got no i_valid at cycle %0d, want %h", cyc, qi[0].data);
        void'(qi.pop_front());
      end
      if (d_valid === 1'b1) begin
        n_cmp++;
        if (qd.size() == 0) begin
          n_bad++;
          $display("FAIL ls_unexpected: got d_valid rdata=%h err=%b at cycle %0d, want none", d_rdata, d_err, cyc);
        end else begin
          e = qd.pop_front();
          if (d_rdata !== e.data || d_err !== e.err || cyc != e.due) begin
            n_bad++;
            $display("FAIL ls_resp: got rdata=%h err=%b at cycle %0d, want rdata=%h err=%b at cycle %0d",
                     d_rdata, d_err, cyc, e.data, e.err, e.due);
          end
        end
      end else begin
        if (d_err !== 1'b0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL err_without_valid: got d_err=%b, want 0", d_err);
        end
        if (qd.size() > 0 && qd[0].due <= cyc) begin
          n_cmp++;
          n_bad++;
          $display("FAIL ls_missing: got no d_valid at cycle %0d, want rdata=%h err=%b", cyc, qd[0].data, qd[0].err);
          void'(qd.pop_front());
        end
      end
    end
  end

  initial begin
    reset      = 1'b1;
    i_req      = 1'b0;
    i_addr     = '0;
    d_req      = 1'b0;
    d_we       = 1'b0;
    d_size     = 2'd0;
    d_unsigned = 1'b0;
    d_addr     = '0;
    d_wdata    = 32'h0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Give words 0..31 known contents before anything is compared.
    for (int w = 0; w < 32; w++) issue(1'b0, 0, 1'b1, 1'b1, 2'd2, 1'b0, 4*w, $urandom);

    issue(1'b0, 0, 1'b1, 1'b1, 2'd2, 1'b0, 'h10, 32'hDEADBEEF);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h10, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b1, 2'd0, 1'b0, 'h13, 32'h00000080);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b0, 'h13, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd0, 1'b1, 'h13, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h10, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b1, 2'd1, 1'b0, 'h21, 32'h0000BEEF);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h22, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h20, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b1, 2'd3, 1'b0, 'h24, 32'h12345678);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h24, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b1, 2'd2, 1'b0, 'h14, 32'hAAAAAAAA);
    issue(1'b1, 5, 1'b1, 1'b1, 2'd1, 1'b0, 'h16, 32'h00001234);
    issue(1'b1, 5, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
    for (int a = 4; a < 8; a++) issue(1'b1, a, 1'b0, 1'b0, 2'd0, 1'b0, 0, 32'h0);
    idle();
    repeat (3) idle();

    // Reset with loads in flight: nothing may come back for them.
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h10, 32'h0);
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h14, 32'h0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    d_req = 1'b0;
    qd.delete();
    qi.delete();
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    issue(1'b0, 0, 1'b1, 1'b0, 2'd2, 1'b0, 'h10, 32'h0);
    issue(1'b1, 5, 1'b1, 1'b0, 2'd2, 1'b0, 'h14, 32'h0);

    for (int t = 0; t < 400; t++)
      issue($urandom_range(0, 3) != 0, $urandom_range(0, 31),
            $urandom_range(0, 3) != 0, $urandom_range(0, 1) != 0,
            2'($urandom_range(0, 3)), $urandom_range(0, 1) != 0,
            $urandom_range(0, 127), $urandom);
    idle();
    repeat (4) @(posedge clk);

    n_cmp++;
    if (qi.size() + qd.size() != 0) begin
      n_bad++;
      $display("FAIL drain: got %0d responses still outstanding, want 0", qi.size() + qd.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/tcm_word_ram.md
# tcm_word_ram

Parametrised dual-port tightly-coupled word memory for the RiscY core, with a fetch port (A) and a load/store port (B). Port B takes byte addresses and RISC-V access sizes. The block generates byte-lane enables itself, aligns store data, extracts and sign/zero-extends load data, and flags misaligned accesses. Each port is a fully pipelined valid handshake with configurable latency. Optional write-to-fetch forwarding covers same-word collisions.

## Interface
Parameters:
- ADDR_W, 11, word-address width; depth = 2**ADDR_W words of 32 bits
- OUT_REG, 0, 1 adds an output register stage on both ports (latency 2 instead of 1)
- FWD, 1, 1 forwards a same-cycle port-B write into the port-A read of the same word

Ports:
- clk  in  1  single clock, all logic on rising edge
- reset  in  1  asynchronous, active-high; clears pipeline/valid state, not memory contents
- i_req  in  1  fetch request
- i_addr  in  ADDR_W  fetch word address
- i_rdata  out  32  fetched word
- i_valid  out  1  i_rdata valid, one-cycle pulse per request
- d_req  in  1  load/store request
- d_we  in  1  1 = store, 0 = load
- d_size  in  2  00 byte, 01 half, 10 word (11 treated as misaligned)
- d_unsigned  in  1  load zero-extend when 1, sign-extend when 0
- d_addr  in  ADDR_W+2  byte address
- d_wdata  in  32  store data, right-justified (bits [7:0] byte, [15:0] half)
- d_rdata  out  32  extended load result; 0 for stores and errors
- d_valid  out  1  completion pulse for every d_req (load, store or error)
- d_err  out  1  misaligned/illegal access, coincident with d_valid

## Operation
- Word index = d_addr[ADDR_W+1:2]; lane offset = d_addr[1:0].
- Misaligned: half with d_addr[0]=1; word with d_addr[1:0]!=0; size 11. A misaligned store performs no write. Any misaligned request completes with d_err=1 and d_rdata=0.
- Store byte enables: byte = 1<<off; half = 4'b0011<<off; word = 4'b1111. Store data is replicated/shifted into the selected lane(s). Unselected bytes remain unchanged.
- Load: read the full word, shift right by 8*off, keep 8/16/32 bits, then extend per d_unsigned.
- A store completes with d_valid=1, d_err=0, d_rdata=0.
- Port A is read-only.
- Collision (i_req and a legal d_req store to the same word, same cycle):
  - FWD=1: i_rdata = old word with the written bytes replaced by the new bytes.
  - FWD=0: i_rdata = old word.
- A port-B load issued the cycle after a store to the same word returns the new data.
- Memory contents are undefined after power-up and are not cleared by reset.

## Timing
- Request accepted on the edge where req=1. The matching valid is high exactly 1+OUT_REG cycles later, for one cycle. A new request may be issued every cycle on each port; responses return in order.
- A store writes the array on the accepting edge.
- Reset values: i_valid=0, d_valid=0, d_err=0, i_rdata=0, d_rdata=0.
- While reset=1: requests are ignored, no writes occur, and no valids are generated.
- Reset asserted mid-flight: all pending valids are dropped immediately (asynchronously). No response is produced for requests in flight.
- First request accepted on the first rising edge after reset deasserts.

## Structure
- Shared package riscy_mem_pkg: size encodings SZ_BYTE/SZ_HALF/SZ_WORD (match funct3[1:0]), and function be_from_size(size, off).
- Sub-module mem_lane_align: combinational store byte-enable/data alignment, load extract/extend, and misalignment detect.
- Storage is an inferred 4-lane byte-write-enable dual-port RAM in the top module. Pipeline registers and forwarding merge are in the top module.

## Test plan
- Store word 0xDEADBEEF at byte addr 0x10, then load word at 0x10 (OUT_REG=0) -> d_valid at T+1 for each; load returns 0xDEADBEEF, d_err=0.
- Store byte 0x80 at 0x13, then load byte signed and unsigned at 0x13 -> 0xFFFFFF80 and 0x00000080; word at 0x10 reads 0x80ADBEEF.
- Store half to 0x21 and load word from 0x22 -> each gets d_valid with d_err=1 and d_rdata=0; word 0x20 is unchanged.
- Same cycle: half store 0x1234 at 0x16 and fetch i_addr=5 (word 0x14 holds 0xAAAAAAAA) -> FWD=1: i_rdata=0x1234AAAA; FWD=0: i_rdata=0xAAAAAAAA.
- OUT_REG=1: back-to-back fetches on 4 consecutive cycles -> 4 consecutive i_valid pulses starting at T+2, in order.
- Assert reset with two loads in flight -> d_valid stays 0 and no response appears; memory contents are preserved.
